vending_input_conditioner: RTL

VENDING_INPUT_CONDITIONER -- requirements
Module: vending_input_conditioner

---
 rtl/vending_input_conditioner.sv | 127 ++++++++++++
 1 files changed

// File: rtl/vending_input_conditioner.sv
// Conditions the coin sensor and two product buttons for vending_controller:
// each input is synchronized and debounced, then turned into one-cycle, mutually exclusive pulses.
module vending_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic coin_raw,
    input  logic btn1_raw,
    input  logic btn2_raw,
    output logic quarter_in,
    output logic select1,
    output logic select2,
    output logic jam
);
    localparam int CW = 4;

    // Channel index: 0 = coin, 1 = product 1, 2 = product 2.
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    deb_q;
    logic [2:0]    deb_next;
    logic [2:0]    rise;
    logic [CW-1:0] cnt      [3];
    logic [CW-1:0] cnt_next [3];

    logic       pend1;
    logic       pend2;
    logic       pend1_next;
    logic       pend2_next;
    logic       q_next;
    logic       s1_next;
    logic       s2_next;
    logic       jam_next;
    logic       coin_req;
    logic       s1_elig;
    logic       s2_elig;
    logic [7:0] jam_cnt;
    logic [7:0] jam_cnt_next;

    assign raw = {btn2_raw, btn1_raw, coin_raw};

    // The counter "reaching" DEBOUNCE_CYCLES is the edge where it would step
    // past DEBOUNCE_CYCLES-1; the level flips and the counter clears instead.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_next[i] = deb[i];
            cnt_next[i] = '0;
            if (sync2[i] != deb[i]) begin
                if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_next[i] = ~deb[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise     = deb & ~deb_q;
    assign coin_req = rise[0] & ~jam;
    assign s1_elig  = rise[1] | pend1;
    assign s2_elig  = rise[2] | pend2;

    always_comb begin
        q_next     = coin_req;
        s1_next    = 1'b0;
        s2_next    = 1'b0;
        pend1_next = 1'b0;
        pend2_next = 1'b0;
        if (s1_elig && s2_elig) begin
            // Ambiguous double selection: drop both, including any pending ones.
            q_next = coin_req;
        end else if (coin_req) begin
            pend1_next = s1_elig;
            pend2_next = s2_elig;
        end else begin
            s1_next = s1_elig;
            s2_next = s2_elig;
        end
    end

    always_comb begin
        jam_cnt_next = '0;
        if (deb[0]) begin
            jam_cnt_next = (jam_cnt == 8'hFF) ? jam_cnt : jam_cnt + 8'd1;
        end
        jam_next = deb_next[0] & (jam | (jam_cnt_next == 8'(JAM_CYCLES)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            deb        <= '0;
            deb_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
            pend1      <= 1'b0;
            pend2      <= 1'b0;
            quarter_in <= 1'b0;
            select1    <= 1'b0;
            select2    <= 1'b0;
            jam_cnt    <= '0;
            jam        <= 1'b0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            deb        <= deb_next;
            deb_q      <= deb;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= cnt_next[i];
            end
            pend1      <= pend1_next;
            pend2      <= pend2_next;
            quarter_in <= q_next;
            select1    <= s1_next;
            select2    <= s2_next;
            jam_cnt    <= jam_cnt_next;
            jam        <= jam_next;
        end
    end

endmodule
